// File: rtl/cam_pixel_capture.sv
// ---------------------------------------------------------------------------
// cam_pixel_capture
//   Frame-capture stage behind the OV7670 input synchronisers (pclk domain).
//   It decodes frame timing from VSYNC and line timing from HREF. It packs each
//   pair of RGB565 bytes into one RGB332 pixel and writes it to the
//   frame-buffer RAM at a linear address. It also reports frame completion and
//   an overflow status for the control side.
//
//   Optional feature: define CAM_FRAME_CNT_EN to add the 8-bit frame_cnt
//   output. The counter wraps 255 -> 0 and steps together with frame_done.
//
// Ports
//   pclk        in   camera pixel clock, all logic on posedge
//   Reset       in   synchronous, active-high reset
//   vsync       in   synchronised VSYNC, high = vertical blanking
//   href        in   synchronised HREF, high = valid byte on cam_data
//   cam_data    in   synchronised camera byte
//   px_data     out  RGB332 pixel {R[2:0],G[2:0],B[1:0]}
//   px_addr     out  write address = pixels already written this frame
//   px_we       out  one-cycle write strobe for px_data/px_addr
//   frame_done  out  one-cycle pulse at the end of a captured frame
//   ovf         out  sticky: the frame delivered more than MAX_PIX pixels
//   frame_cnt   out  (CAM_FRAME_CNT_EN only) completed-frame counter
// ---------------------------------------------------------------------------
module cam_pixel_capture #(
    parameter int AW       = 15,
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 120
) (
    input  logic          pclk,
    input  logic          Reset,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    cam_data,
    output logic [7:0]    px_data,
    output logic [AW-1:0] px_addr,
    output logic          px_we,
    output logic          frame_done,
`ifdef CAM_FRAME_CNT_EN
    output logic [7:0]    frame_cnt,
`endif
    output logic          ovf
);

    localparam int            MAX_PIX   = H_PIXELS * V_LINES;
    localparam logic [AW:0]   MAX_PIX_W = (AW+1)'(MAX_PIX);

    typedef enum logic [0:0] {
        S_WAIT_VS = 1'b0,
        S_FRAME   = 1'b1
    } state_t;

    state_t        state_q;
    logic          vs_q;
    logic          phase_q;
    logic [7:0]    byte1_q;
    logic          done_pend_q;
    logic [7:0]    px_data_q;
    logic [AW-1:0] px_addr_q;
    logic          px_we_q;
    logic          frame_done_q;
    logic          ovf_q;
`ifdef CAM_FRAME_CNT_EN
    logic [7:0]    frame_cnt_q;
`endif

    // px_addr_q only advances the cycle after a strobe. A strobe that is still
    // in flight must therefore be counted when testing the frame limit.
    logic [AW:0] written;
    logic        cap_hit;
    logic        vs_fall;
    logic        vs_rise;
    logic        pix_done;

    assign written  = {1'b0, px_addr_q} + (AW+1)'(px_we_q);
    assign cap_hit  = (written >= MAX_PIX_W);
    assign vs_fall  = vs_q & ~vsync;
    assign vs_rise  = ~vs_q & vsync;
    assign pix_done = href & phase_q & ~cap_hit;

    always_ff @(posedge pclk) begin
        if (Reset) begin
            state_q      <= S_WAIT_VS;
            vs_q         <= 1'b0;
            phase_q      <= 1'b0;
            byte1_q      <= 8'h00;
            done_pend_q  <= 1'b0;
            px_data_q    <= 8'h00;
            px_addr_q    <= '0;
            px_we_q      <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef CAM_FRAME_CNT_EN
            frame_cnt_q  <= 8'h00;
`endif
        end else begin
            vs_q         <= vsync;
            px_we_q      <= 1'b0;
            frame_done_q <= 1'b0;
            done_pend_q  <= 1'b0;
            if (px_we_q) begin
                px_addr_q <= px_addr_q + AW'(1);
            end

            case (state_q)
                S_WAIT_VS: begin
                    // Deferred pulse: the frame ended on the cycle of its
                    // last pixel, so the write strobe goes out first.
                    if (done_pend_q) begin
                        frame_done_q <= 1'b1;
`ifdef CAM_FRAME_CNT_EN
                        frame_cnt_q  <= frame_cnt_q + 8'd1;
`endif
                    end
                    if (vs_fall) begin
                        state_q   <= S_FRAME;
                        px_addr_q <= '0;
                        phase_q   <= 1'b0;
                        ovf_q     <= 1'b0;
                    end
                end

                S_FRAME: begin
                    if (href) begin
                        if (!phase_q) begin
                            byte1_q <= cam_data;
                            phase_q <= 1'b1;
                        end else begin
                            phase_q <= 1'b0;
                            if (cap_hit) begin
                                ovf_q <= 1'b1;
                            end else begin
                                // byte1 = R[4:0],G[5:3]; cam_data = G[2:0],B[4:0]
                                px_data_q <= {byte1_q[7:5], byte1_q[2:0], cam_data[4:3]};
                                px_we_q   <= 1'b1;
                            end
                        end
                    end else begin
                        // A line that ends on an odd byte drops the half pixel.
                        phase_q <= 1'b0;
                    end

                    if (vs_rise) begin
                        state_q <= S_WAIT_VS;
                        if (pix_done) begin
                            done_pend_q <= 1'b1;
                        end else begin
                            frame_done_q <= 1'b1;
`ifdef CAM_FRAME_CNT_EN
                            frame_cnt_q  <= frame_cnt_q + 8'd1;
`endif
                        end
                    end
                end

                default: state_q <= S_WAIT_VS;
            endcase
        end
    end

    assign px_data    = px_data_q;
    assign px_addr    = px_addr_q;
    assign px_we      = px_we_q;
    assign frame_done = frame_done_q;
    assign ovf        = ovf_q;
`ifdef CAM_FRAME_CNT_EN
    assign frame_cnt  = frame_cnt_q;
`endif

endmodule

// File: tb/tb_cam_pixel_capture.sv
// ---------------------------------------------------------------------------
// tb_cam_pixel_capture
//   Self-checking bench for cam_pixel_capture. A monitor records every write
//   strobe and frame_done pulse. A reference model turns the driven byte
//   stream into the expected RGB332 pixel list: bytes are paired within each
//   HREF run, leftover odd bytes are dropped, and the frame is capped at
//   MAX_PIX pixels.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cam_pixel_capture;

    localparam int AW      = 15;
    localparam int MAX_PIX = 160 * 120;

    logic          pclk = 1'b0;
    logic          Reset;
    logic          vsync;
    logic          href;
    logic [7:0]    cam_data;
    logic [7:0]    px_data;
    logic [AW-1:0] px_addr;
    logic          px_we;
    logic          frame_done;
    logic          ovf;
`ifdef CAM_FRAME_CNT_EN
    logic [7:0]    frame_cnt;
`endif

    cam_pixel_capture #(.AW(AW), .H_PIXELS(160), .V_LINES(120)) dut (
        .pclk       (pclk),
        .Reset      (Reset),
        .vsync      (vsync),
        .href       (href),
        .cam_data   (cam_data),
        .px_data    (px_data),
        .px_addr    (px_addr),
        .px_we      (px_we),
        .frame_done (frame_done),
`ifdef CAM_FRAME_CNT_EN
        .frame_cnt  (frame_cnt),
`endif
        .ovf        (ovf)
    );

    always #5 pclk = ~pclk;

    int errs = 0;
    int chks = 0;
    int cyc  = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // Monitor state
    int wq_addr[$];
    int wq_data[$];
    int wq_cyc[$];
    int done_cnt = 0;
    int tot_done = 0;
    int done_cyc = 0;
    int viol     = 0;
    logic prev_we = 1'b0, prev_done = 1'b0;

    always @(negedge pclk) begin
        if (px_we === 1'b1) begin
            wq_addr.push_back(int'(px_addr));
            wq_data.push_back(int'(px_data));
            wq_cyc.push_back(cyc);
            if (prev_we) viol++;
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            tot_done++;
            done_cyc = cyc;
            if (px_we === 1'b1) viol++;
            if (prev_done) viol++;
        end
        prev_we   = px_we;
        prev_done = frame_done;
    end

    // Reference model
    logic [7:0] line_q[$];
    int         exp_q[$];
    int         last_drive_cyc;

    function automatic int rgb565_to_332(input int b1, input int b2);
        int r5, g6, b5;
        r5 = b1 / 8;
        g6 = (b1 % 8) * 8 + b2 / 32;
        b5 = b2 % 32;
        return (r5 / 4) * 32 + (g6 / 8) * 4 + (b5 / 8);
    endfunction

    task automatic model_line();
        for (int i = 0; i + 1 < line_q.size(); i += 2)
            if (exp_q.size() < MAX_PIX)
                exp_q.push_back(rgb565_to_332(int'(line_q[i]), int'(line_q[i+1])));
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic clear_obs();
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic rand_line(input int nbytes);
        line_q.delete();
        for (int i = 0; i < nbytes; i++) line_q.push_back(8'($urandom));
    endtask

    task automatic drive_line();
        for (int i = 0; i < line_q.size(); i++) begin
            tick();
            href = 1'b1; cam_data = line_q[i];
            last_drive_cyc = cyc;
        end
        tick();
        href = 1'b0; cam_data = 8'($urandom);
    endtask

    task automatic frame_start();
        tick(); vsync = 1'b1;
        tick();
        tick(); vsync = 1'b0;
        tick();
    endtask

    task automatic frame_end();
        tick(); vsync = 1'b1;
        repeat (4) tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            href = 1'($urandom); vsync = 1'($urandom); cam_data = 8'($urandom);
        end
        tick();
        href = 1'b0; vsync = 1'b1;
        chks++; if (px_we !== 1'b0)      begin errs++; $display("FAIL reset_we got=%b exp=0", px_we); end
        chks++; if (frame_done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        chks++; if (ovf !== 1'b0)        begin errs++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        chks++; if (px_addr !== '0)      begin errs++; $display("FAIL reset_addr got=%0d exp=0", px_addr); end
        chks++; if (px_data !== 8'h00)   begin errs++; $display("FAIL reset_data got=%h exp=00", px_data); end
`ifdef CAM_FRAME_CNT_EN
        chks++; if (frame_cnt !== 8'h00) begin errs++; $display("FAIL reset_fcnt got=%0d exp=0", frame_cnt); end
`endif
        Reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        int lat;
        clear_obs();
        frame_start();
        line_q.delete(); line_q.push_back(8'hF8); line_q.push_back(8'h1F);
        model_line(); drive_line();
        lat = last_drive_cyc + 1;
        rand_line(2); model_line(); drive_line();
        frame_end();
        chks++; if (wq_data.size() != 2) begin errs++; $display("FAIL basic_count got=%0d exp=2", wq_data.size()); end
        if (wq_data.size() >= 2) begin
            chks++; if (wq_data[0] != 8'hE3) begin errs++; $display("FAIL basic_px0 got=%h exp=e3", wq_data[0]); end
            chks++; if (wq_addr[0] != 0)     begin errs++; $display("FAIL basic_addr0 got=%0d exp=0", wq_addr[0]); end
            chks++; if (wq_cyc[0] != lat)    begin errs++; $display("FAIL basic_latency got=%0d exp=%0d", wq_cyc[0], lat); end
            chks++; if (wq_addr[1] != 1)     begin errs++; $display("FAIL basic_addr1 got=%0d exp=1", wq_addr[1]); end
            chks++; if (wq_data[1] != exp_q[1]) begin errs++; $display("FAIL basic_px1 got=%h exp=%h", wq_data[1], exp_q[1]); end
        end
        chks++; if (done_cnt != 1) begin errs++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_href_drop();
        clear_obs();
        frame_start();
        line_q.delete(); line_q.push_back(8'hFF); line_q.push_back(8'hFF); line_q.push_back(8'h00);
        model_line(); drive_line();
        rand_line(2); model_line(); drive_line();
        frame_end();
        chks++; if (wq_data.size() != 2) begin errs++; $display("FAIL drop_count got=%0d exp=2", wq_data.size()); end
        if (wq_data.size() >= 2) begin
            chks++; if (wq_data[0] != 8'hFF) begin errs++; $display("FAIL drop_px0 got=%h exp=ff", wq_data[0]); end
            chks++; if (wq_data[1] != exp_q[1] || wq_addr[1] != 1)
                begin errs++; $display("FAIL drop_px1 got=%h@%0d exp=%h@1", wq_data[1], wq_addr[1], exp_q[1]); end
        end
    endtask

    task automatic test_full_frame(input int extra);
        int n;
        clear_obs();
        frame_start();
        for (int l = 0; l < 120; l++) begin
            rand_line((l == 119) ? 320 + 2 * extra : 320);
            model_line(); drive_line();
        end
        frame_end();
        n = wq_data.size();
        chks++; if (n != MAX_PIX) begin errs++; $display("FAIL full_count got=%0d exp=%0d", n, MAX_PIX); end
        for (int i = 0; i < n && i < MAX_PIX; i++) begin
            chks++;
            if (wq_addr[i] != i || wq_data[i] != exp_q[i]) begin
                errs++;
                $display("FAIL full_px[%0d] got=%h@%0d exp=%h@%0d", i, wq_data[i], wq_addr[i], exp_q[i], i);
                break;
            end
        end
        if (n > 0) begin
            chks++; if (wq_addr[n-1] != MAX_PIX - 1) begin errs++; $display("FAIL full_last_addr got=%0d exp=%0d", wq_addr[n-1], MAX_PIX - 1); end
        end
        chks++; if (done_cnt != 1) begin errs++; $display("FAIL full_done got=%0d exp=1", done_cnt); end
        chks++; if (ovf !== (extra > 0)) begin errs++; $display("FAIL full_ovf got=%b exp=%0d", ovf, extra > 0); end
        if (extra > 0) begin
            frame_start();
            chks++; if (ovf !== 1'b0) begin errs++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
            frame_end();
        end
    endtask

    task automatic test_vsync_coincide();
        int a, b;
        clear_obs();
        frame_start();
        a = int'($urandom_range(255)); b = int'($urandom_range(255));
        tick(); href = 1'b1; cam_data = 8'(a);
        tick(); cam_data = 8'(b); vsync = 1'b1;
        tick(); href = 1'b0;
        repeat (4) tick();
        chks++; if (wq_data.size() != 1) begin errs++; $display("FAIL coinc_count got=%0d exp=1", wq_data.size()); end
        if (wq_data.size() == 1) begin
            chks++; if (wq_data[0] != rgb565_to_332(a, b)) begin errs++; $display("FAIL coinc_px got=%h exp=%h", wq_data[0], rgb565_to_332(a, b)); end
            chks++; if (done_cnt != 1 || done_cyc <= wq_cyc[0])
                begin errs++; $display("FAIL coinc_order got=done%0d@%0d exp=1 after we@%0d", done_cnt, done_cyc, wq_cyc[0]); end
        end
    endtask

    task automatic test_reset_midframe();
        clear_obs();
        frame_start();
        rand_line(500); drive_line();
        rand_line(500); drive_line();
        Reset = 1'b1; tick(); tick(); Reset = 1'b0;
        chks++; if (px_addr !== '0) begin errs++; $display("FAIL rst_mid_addr got=%0d exp=0", px_addr); end
        frame_end();
        chks++; if (done_cnt != 0) begin errs++; $display("FAIL rst_mid_done got=%0d exp=0", done_cnt); end
        clear_obs();
        frame_start();
        rand_line(6); model_line(); drive_line();
        frame_end();
        chks++; if (wq_data.size() != 3) begin errs++; $display("FAIL rst_next_count got=%0d exp=3", wq_data.size()); end
        if (wq_data.size() > 0) begin
            chks++; if (wq_addr[0] != 0 || wq_data[0] != exp_q[0])
                begin errs++; $display("FAIL rst_next_px0 got=%h@%0d exp=%h@0", wq_data[0], wq_addr[0], exp_q[0]); end
        end
        chks++; if (done_cnt != 1) begin errs++; $display("FAIL rst_next_done got=%0d exp=1", done_cnt); end
    endtask

`ifdef CAM_FRAME_CNT_EN
    task automatic test_frame_cnt();
        Reset = 1'b1; tick(); tick(); Reset = 1'b0; vsync = 1'b1;
        clear_obs();
        for (int f = 0; f < 256; f++) begin
            frame_start();
            rand_line(2); drive_line();
            tick(); vsync = 1'b1;
            tick();
            if (f == 0) begin
                tick();
                chks++; if (frame_cnt !== 8'd1) begin errs++; $display("FAIL fcnt_first got=%0d exp=1", frame_cnt); end
            end
        end
        repeat (3) tick();
        chks++; if (done_cnt != 256) begin errs++; $display("FAIL fcnt_pulses got=%0d exp=256", done_cnt); end
        chks++; if (frame_cnt !== 8'd0) begin errs++; $display("FAIL fcnt_wrap got=%0d exp=0", frame_cnt); end
    endtask
`endif

    task automatic test_pulse_rules();
        chks++; if (viol != 0) begin errs++; $display("FAIL pulse_rules got=%0d violations exp=0", viol); end
    endtask

    initial begin
        Reset = 1'b1; vsync = 1'b1; href = 1'b0; cam_data = 8'h00;
        last_drive_cyc = 0;
        test_reset();
        test_basic();
        test_href_drop();
        test_vsync_coincide();
        test_full_frame(0);
        test_full_frame(1);
        test_reset_midframe();
`ifdef CAM_FRAME_CNT_EN
        test_frame_cnt();
`endif
        test_pulse_rules();
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
